// File: rtl/serv_pkg.sv
// Shared definitions for the serv fetch front end: fetch FSM encodings,
// RV32 instruction field positions and the uncompressed opcode quadrant.
package serv_pkg;

  // Fetch FSM encodings
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;
  localparam logic [1:0] ST_GAP     = 2'd3;

  // Instruction field bit positions
  localparam int OPC_LSB   = 2;
  localparam int OPC_MSB   = 6;
  localparam int F3_LSB    = 12;
  localparam int F3_MSB    = 14;
  localparam int OP20_BIT  = 20;
  localparam int OP21_BIT  = 21;
  localparam int OP22_BIT  = 22;
  localparam int IMM25_BIT = 25;
  localparam int OP26_BIT  = 26;
  localparam int IMM30_BIT = 30;

  // insn[1:0] of every 32-bit (non-compressed) RV32 instruction
  localparam logic [1:0] RV32_QUADRANT = 2'b11;

endpackage

// File: rtl/serv_ibus_fetch_if.sv
// Wishbone-classic instruction bus (read-only) between the fetch unit and memory.
interface serv_ibus_fetch_if;

  // Handshake: the master holds o_ibus_cyc high with a stable o_ibus_adr until
  // the slave answers with a single-cycle i_ibus_ack, qualifying i_ibus_rdt on
  // that same cycle; the master then drops o_ibus_cyc for at least one cycle.
  logic [31:0] o_ibus_adr;
  logic        o_ibus_cyc;
  logic [31:0] i_ibus_rdt;
  logic        i_ibus_ack;

  modport master (output o_ibus_adr, output o_ibus_cyc,
                  input  i_ibus_rdt, input  i_ibus_ack);

  modport slave  (input  o_ibus_adr, input  o_ibus_cyc,
                  output i_ibus_rdt, output i_ibus_ack);

endinterface

// File: rtl/serv_ibus_fetch.sv
// Instruction fetch front end: runs ibus read cycles at the requested PC,
// captures the word and presents the decoder field slices with a one-cycle
// o_dec_en strobe. Handles redirect (flush) and a bus watchdog.
module serv_ibus_fetch
  import serv_pkg::*;
#(
  parameter int          TIMEOUT_W   = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic        RESET_FETCH = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_fetch_req,
  input  logic               i_flush,
  input  logic [31:0]        i_pc,
  serv_ibus_fetch_if.master  ibus,
  output logic               o_dec_en,
  output logic [4:0]         o_opcode,
  output logic [2:0]         o_funct3,
  output logic               o_imm30,
  output logic               o_imm25,
  output logic               o_op20,
  output logic               o_op21,
  output logic               o_op22,
  output logic               o_op26,
  output logic [31:0]        o_insn,
  output logic               o_illegal,
  output logic               o_fault,
  output logic               o_busy,
  output logic [1:0]         o_dbg_state
);

  // Last counter value before it would reach all-ones; reaching all-ones ends the cycle
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  logic [1:0]           state;
  logic [31:0]          adr;
  logic [31:0]          pend_pc;   // redirect target while a dropped word is still in flight
  logic                 pend_go;   // GAP must be followed by BUSY at adr
  logic                 boot;      // automatic first fetch after reset
  logic [TIMEOUT_W-1:0] wdog;
  logic [31:0]          insn;
  logic                 dec_en;
  logic                 fault;
  logic [31:0]          pc_al;

  assign pc_al = i_pc & ~32'h3;

  // Fetch FSM, address/pending tracking, watchdog and word capture
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      adr     <= RESET_PC & ~32'h3;
      pend_pc <= 32'h0;
      pend_go <= 1'b0;
      boot    <= RESET_FETCH;
      wdog    <= '0;
      insn    <= 32'h0;
      dec_en  <= 1'b0;
      fault   <= 1'b0;
    end else begin
      dec_en <= 1'b0;
      fault  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_flush || i_fetch_req) begin
            adr   <= pc_al;
            state <= ST_BUSY;
            wdog  <= '0;
            boot  <= 1'b0;
          end else if (boot) begin
            state <= ST_BUSY;
            wdog  <= '0;
            boot  <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (ibus.i_ibus_ack) begin
            // A flush on the ack cycle drops the word and refetches after the gap
            if (i_flush) begin
              adr     <= pc_al;
              pend_go <= 1'b1;
            end else begin
              insn   <= ibus.i_ibus_rdt;
              dec_en <= 1'b1;
            end
            state <= ST_GAP;
          end else if (i_flush) begin
            pend_pc <= pc_al;
            state   <= ST_DISCARD;
            wdog    <= '0;
          end else if (wdog == WD_LAST) begin
            fault   <= 1'b1;
            pend_go <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            wdog <= wdog + WD_ONE;
          end
        end
        ST_DISCARD: begin
          if (ibus.i_ibus_ack) begin
            adr     <= i_flush ? pc_al : pend_pc;
            pend_go <= 1'b1;
            state   <= ST_GAP;
          end else if (wdog == WD_LAST) begin
            fault   <= 1'b1;
            pend_go <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            wdog <= wdog + WD_ONE;
            if (i_flush) pend_pc <= pc_al;
          end
        end
        default: begin // ST_GAP
          if (i_flush) begin
            adr     <= pc_al;
            pend_go <= 1'b0;
            state   <= ST_BUSY;
            wdog    <= '0;
          end else if (pend_go) begin
            pend_go <= 1'b0;
            state   <= ST_BUSY;
            wdog    <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Bus and status outputs decode straight from state so reset drops cyc at once
  always_comb begin
    ibus.o_ibus_cyc = (state == ST_BUSY) || (state == ST_DISCARD);
    ibus.o_ibus_adr = adr;
    o_busy          = (state != ST_IDLE);
    o_dbg_state     = state;
  end

  assign o_dec_en  = dec_en;
  assign o_fault   = fault;
  assign o_insn    = insn;
  assign o_opcode  = insn[OPC_MSB:OPC_LSB];
  assign o_funct3  = insn[F3_MSB:F3_LSB];
  assign o_imm30   = insn[IMM30_BIT];
  assign o_imm25   = insn[IMM25_BIT];
  assign o_op20    = insn[OP20_BIT];
  assign o_op21    = insn[OP21_BIT];
  assign o_op22    = insn[OP22_BIT];
  assign o_op26    = insn[OP26_BIT];
  assign o_illegal = dec_en && (insn[1:0] != RV32_QUADRANT);

endmodule
